// File: rtl/pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package pattern_pkg;

    // One-hot controller states.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_SEND = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Target sequence of the downstream pattern detector.
    localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;
    localparam int         DEFAULT_LEN     = 5;

endpackage

// File: rtl/pattern_gen_if.sv
// Control/config inputs and serial outputs of the pattern transmitter.
interface pattern_gen_if
    import pattern_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
);
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic [CNT_W-1:0]   repeat_cnt;
    logic [GAP_W-1:0]   gap_len;
    logic               data_out;
    logic               data_valid;
    logic               frame_start;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, pattern, pat_len, repeat_cnt, gap_len,
        input  data_out, data_valid, frame_start, busy, done
    );

    modport slave (
        input  start, abort, pattern, pat_len, repeat_cnt, gap_len,
        output data_out, data_valid, frame_start, busy, done
    );
endinterface

// File: rtl/pattern_shreg.sv
// Loadable MSB-first shift register; the pattern is left-aligned on load so
// the first bit to send always sits at the top, and a down-counter flags the
// final bit of the repetition.
module pattern_shreg
    import pattern_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               msb,
    output logic               last_bit
);
    logic [MAX_LEN-1:0] data_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   shamt;

    // len is already clamped to 1..MAX_LEN whenever load is asserted.
    assign shamt    = LEN_W'(MAX_LEN) - len;
    assign msb      = data_q[MAX_LEN-1];
    assign last_bit = (cnt_q == '0);

    // Load takes priority so a back-to-back reload restarts the pattern.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= pattern << shamt;
            cnt_q  <= len - LEN_W'(1);
        end else if (shift) begin
            data_q <= {data_q[MAX_LEN-2:0], 1'b0};
            cnt_q  <= cnt_q - LEN_W'(1);
        end
    end
endmodule

// File: rtl/pattern_gen.sv
// Bit-serial pattern transmitter: sends a latched pattern MSB-first, repeated
// a programmable number of times with optional idle gaps in between.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   SEND  | shifting pattern bits out, data_valid=1
//   GAP   | idle cycles between repetitions, busy=1
//   DONE  | one-cycle done pulse, then back to IDLE
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    pattern_gen_if.slave   bus
);
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   rep_q;
    logic [GAP_W-1:0]   gap_len_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               first_q;

    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] sh_pattern;
    logic [LEN_W-1:0]   sh_len;
    logic               accept, sh_load, sh_shift, rep_dec, gap_load, gap_dec;
    logic               msb, last_bit;

    assign len_clamp = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;

    // The first load comes straight from the inputs; reloads use the latched copy.
    assign sh_pattern = (state_q == ST_IDLE) ? bus.pattern : pat_q;
    assign sh_len     = (state_q == ST_IDLE) ? len_clamp   : len_q;

    pattern_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .pattern  (sh_pattern),
        .len      (sh_len),
        .msb      (msb),
        .last_bit (last_bit)
    );

    // State register, latched configuration, repeat and gap down-counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= sh_load;
            if (accept) begin
                pat_q     <= bus.pattern;
                len_q     <= len_clamp;
                rep_q     <= bus.repeat_cnt;
                gap_len_q <= bus.gap_len;
            end else if (rep_dec) begin
                rep_q <= rep_q - CNT_W'(1);
            end
            if (gap_load) begin
                gap_cnt_q <= gap_len_q;
            end else if (gap_dec) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        sh_load         = 1'b0;
        sh_shift        = 1'b0;
        rep_dec         = 1'b0;
        gap_load        = 1'b0;
        gap_dec         = 1'b0;
        bus.data_out    = 1'b0;
        bus.data_valid  = 1'b0;
        bus.frame_start = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (len_clamp == '0 || bus.repeat_cnt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                        sh_load = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                bus.data_valid  = 1'b1;
                bus.data_out    = msb;
                bus.frame_start = first_q;
                bus.busy        = 1'b1;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (last_bit) begin
                    if (rep_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rep_dec = 1'b1;
                        if (gap_len_q != '0) begin
                            gap_load = 1'b1;
                            state_d  = ST_GAP;
                        end else begin
                            sh_load = 1'b1;
                        end
                    end
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_GAP: begin
                bus.busy = 1'b1;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    sh_load = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: each run pushes the expected per-cycle
// output vector {data_out, data_valid, frame_start, busy, done} and pops one
// entry per cycle, sampled on the falling edge.
module tb_pattern_gen;
    import pattern_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pattern_gen_if bus ();

    pattern_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [4:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.data_out, bus.data_valid, bus.frame_start, bus.busy, bus.done};
    endfunction

    // Drive one transmission and score every cycle until the model runs dry.
    // restart_at/abort_at/rst_at give the cycle (counted from the first bit)
    // during which that input is pulsed; -1 disables it.
    task automatic run_case(input string name, input logic [15:0] pat, input logic [4:0] len,
                            input logic [7:0] rc, input logic [3:0] gl,
                            input int restart_at, input int abort_at, input int rst_at,
                            input bit abort_with_start, input int exp_hits);
        int         len_eff;
        int         c;
        int         hit_cnt;
        logic [4:0] window;
        logic [4:0] e;
        len_eff = (len > 5'd16) ? 16 : int'(len);
        exp_q.delete();
        if (len_eff == 0 || rc == 8'd0) begin
            exp_q.push_back(5'b00001);
        end else begin
            for (int r = 0; r < int'(rc); r++) begin
                for (int b = len_eff - 1; b >= 0; b--)
                    exp_q.push_back({pat[b], 1'b1, (b == len_eff - 1), 1'b1, 1'b0});
                if (r < int'(rc) - 1)
                    for (int g = 0; g < int'(gl); g++) exp_q.push_back(5'b00010);
            end
            exp_q.push_back(5'b00001);
        end
        exp_q.push_back(5'b00000);

        @(negedge clk);
        bus.pattern    = pat;
        bus.pat_len    = len;
        bus.repeat_cnt = rc;
        bus.gap_len    = gl;
        bus.start      = 1'b1;
        bus.abort      = abort_with_start;
        @(negedge clk);
        // Scramble config so anything not latched at the accepting edge shows up.
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = ~pat;
        bus.pat_len    = len ^ 5'd3;
        bus.repeat_cnt = rc + 8'd1;
        bus.gap_len    = gl ^ 4'd5;

        c       = 1;
        hit_cnt = 0;
        window  = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s c%0d", name, c), 32'(outs()), 32'(e));
            if (bus.data_valid) begin
                window = {window[3:0], bus.data_out};
                if (window == DEFAULT_PATTERN) hit_cnt++;
            end
            bus.start = (c == restart_at);
            bus.abort = (c == abort_at);
            rst       = (c != rst_at);
            if (c == abort_at || c == rst_at) begin
                exp_q.delete();
                repeat (4) exp_q.push_back(5'b00000);
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b1;
        if (exp_hits >= 0) check_val({name, " hits"}, 32'(hit_cnt), 32'(exp_hits));
    endtask

    initial begin
        logic [15:0] def_pat;
        def_pat        = 16'(DEFAULT_PATTERN);
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.pat_len    = '0;
        bus.repeat_cnt = '0;
        bus.gap_len    = '0;
        repeat (3) @(negedge clk);
        check_val("reset outs", 32'(outs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("idle outs", 32'(outs()), 32'd0);

        run_case("single",   def_pat,  5'(DEFAULT_LEN), 8'd1, 4'd0, -1, -1, -1, 1'b0, 1);
        run_case("rep3gap2", def_pat,  5'(DEFAULT_LEN), 8'd3, 4'd2, -1, -1, -1, 1'b0, 3);
        run_case("len0",     def_pat,  5'd0,  8'd3, 4'd1, -1, -1, -1, 1'b0, -1);
        run_case("rep0",     def_pat,  5'd5,  8'd0, 4'd1, -1, -1, -1, 1'b0, -1);
        run_case("clamp",    16'hA5C3, 5'd20, 8'd1, 4'd0, -1, -1, -1, 1'b1, -1);
        run_case("abort",    def_pat,  5'd5,  8'd2, 4'd0,  3,  4, -1, 1'b0, -1);
        run_case("after_ab", def_pat,  5'd5,  8'd2, 4'd0, -1, -1, -1, 1'b0, 2);
        run_case("gap_ab",   def_pat,  5'd5,  8'd2, 4'd3, -1,  7, -1, 1'b0, -1);
        run_case("rst_mid",  def_pat,  5'd5,  8'd1, 4'd0, -1, -1,  3, 1'b0, -1);
        run_case("after_rs", def_pat,  5'd5,  8'd1, 4'd0, -1, -1, -1, 1'b0, 1);
        run_case("len1",     16'h0001, 5'd1,  8'd3, 4'd1, -1, -1, -1, 1'b0, -1);
        run_case("len16",    16'h8001, 5'd16, 8'd2, 4'd0, -1, -1, -1, 1'b0, -1);
        run_case("rep255",   def_pat,  5'd5,  8'd255, 4'd0, -1, -1, -1, 1'b0, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Bit-serial pattern transmitter: the stimulus end of the pattern-detector link.
- Latches a programmable pattern of up to MAX_LEN bits and shifts it out MSB-first on data_out, one bit per clock.
- Repeats the pattern a programmable number of times, with optional idle gaps between repetitions.
- Output drives a detector's data_in directly; frame_start marks pattern boundaries for scoreboarding.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits.
- LEN_W, 5, width of pat_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8, width of repeat_cnt.
- GAP_W, 4, width of gap_len.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request transmission; sampled only in IDLE.
- abort  in  1  synchronous cancel of an in-progress transmission.
- pattern  in  MAX_LEN  pattern bits, right-aligned; bit pat_len-1 is sent first.
- pat_len  in  LEN_W  pattern length; 0 means empty; values above MAX_LEN clamp to MAX_LEN.
- repeat_cnt  in  CNT_W  number of repetitions; 0 means none.
- gap_len  in  GAP_W  idle cycles between repetitions; no gap follows the last repetition.
- data_out  out  1  serial bit; 0 whenever data_valid=0.
- data_valid  out  1  data_out carries a pattern bit.
- frame_start  out  1  pulse coincident with bit 0 (the MSB) of each repetition.
- busy  out  1  transmission in progress (SEND or GAP state).
- done  out  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; all outputs 0; internal shift register and counters cleared. Reset mid-transmission truncates the stream immediately; no done pulse.
- State machine, one-hot, four states: IDLE, SEND, GAP, DONE.
- IDLE, start=1 at edge T:
  - Latch pattern, clamped length L, repeat_cnt R and gap_len G.
  - If L=0 or R=0: go to DONE.
  - Otherwise go to SEND.
- SEND:
  - data_valid=1; data_out = current MSB of the shift register; busy=1.
  - First bit appears in cycle T+1 (latency 1 from start).
  - On the last bit of a repetition:
    - more repetitions left and G>0: go to GAP;
    - more repetitions left and G=0: reload and stay in SEND (back-to-back bits);
    - last repetition: go to DONE.
- GAP: data_out=0, data_valid=0, busy=1 for exactly G cycles; reload the pattern, then go to SEND.
- DONE: done=1, busy=0 for exactly one cycle; then IDLE.
- frame_start=1 only in the SEND cycle carrying the first bit of a repetition.
- Total cycles from T+1 to the last bit inclusive = R*L + (R-1)*G.
- start ignored while busy=1 and during the DONE cycle. Config inputs are don't-care except at the accepting edge.
- abort=1 in SEND or GAP: next cycle IDLE; outputs 0; no done pulse. abort in IDLE or DONE has no effect.
- abort and start in the same IDLE cycle: start wins.
- Repetition counter counts down from R with no wrap. R=2^CNT_W-1 must complete correctly.

Decomposition:
- pattern_pkg holds:
  - one-hot state constants (4'b0001, 4'b0010, 4'b0100, 4'b1000);
  - DEFAULT_PATTERN=5'b10110 and DEFAULT_LEN=5, the detector's target sequence.
- One sub-module, pattern_shreg: loadable MAX_LEN shift register with a bit counter.
  - Inputs: load, shift, pattern, len.
  - Outputs: msb, last_bit.
- The FSM, repeat counter and gap counter stay in pattern_gen.

Test Plan:
- pattern=10110, L=5, R=1, G=0, start at cycle 0 -> data_out 1,0,1,1,0 with data_valid=1 in cycles 1-5; frame_start at cycle 1; done at cycle 6; busy high in cycles 1-5 only.
- Same pattern, R=3, G=2 -> 19 active cycles (1-19); data_valid low in cycles 6-7 and 13-14; frame_start at cycles 1, 8 and 15; done at cycle 20. A detector on data_out flags 3 hits.
- L=0 or R=0, start at cycle 0 -> data_valid never asserted; done at cycle 1.
- pat_len=20 with MAX_LEN=16, pattern=16'hA5C3 -> exactly 16 bits sent, MSB-first (1010 0101 1100 0011); done at cycle 17.
- R=2, G=0: start re-pulsed at cycle 3 -> ignored, stream unchanged. abort at cycle 4 -> cycle 5 idle with outputs 0, no done pulse. A later start works normally.
- rst=0 at cycle 3 of a 5-bit transmission -> cycle 4 all outputs 0, state IDLE; after release, a new start produces the full pattern from its first bit.
